// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multi-cycle RISC-V sequencing FSM (fetch/decode/exec/mem/wb) with shared-memory arbitration.
// Define MULTI_CYCLE_PERF_CNT_EN to enable the cycle/instret counters (outputs read 0 otherwise).
module multi_cycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode_i,
  input  logic        branch_taken_i,
  input  logic        mem_ready_i,
  output logic [2:0]  ALU_Op_o,
  output logic        ALU_Src_B_o,
  output logic        IorD_o,
  output logic        Mem_Req_o,
  output logic        Mem_Write_o,
  output logic        IR_Write_o,
  output logic        PC_Write_o,
  output logic        PC_Src_o,
  output logic        Reg_Write_o,
  output logic [1:0]  Result_Src_o,
  output logic        Instr_Done_o,
  output logic        Illegal_o,
  output logic [31:0] Cycle_Count_o,
  output logic [31:0] Instret_o
);
  typedef enum logic [3:0] {
    RST, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_READ, MEM_WB,
    MEM_WRITE, ALU_WB, BRANCH, JAL, LUI_WB, HALT
  } state_t;
  state_t state, state_n;
  logic [2:0] op_class;
  logic ir_write, pc_write, reg_write, mem_write;
  always_comb
    op_class = opcode_i == 7'b0110011 ? 3'b000 :
               opcode_i == 7'b0010011 ? 3'b001 :
               opcode_i == 7'b0110111 ? 3'b010 :
               opcode_i == 7'b1100011 ? 3'b011 :
               opcode_i == 7'b0100011 ? 3'b100 :
               opcode_i == 7'b0000011 ? 3'b101 :
               opcode_i == 7'b1101111 ? 3'b111 : 3'b000;
  always_ff @(posedge clk)
    if (reset) begin
      state    <= RST;
      ALU_Op_o <= 3'b000;
    end else begin
      state <= state_n;
      if (state == DECODE) ALU_Op_o <= op_class;
    end
  always_comb begin
    state_n      = state;
    ALU_Src_B_o  = 1'b0;
    IorD_o       = 1'b0;
    Mem_Req_o    = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    PC_Src_o     = 1'b0;
    reg_write    = 1'b0;
    Result_Src_o = 2'b00;
    Instr_Done_o = 1'b0;
    Illegal_o    = 1'b0;
    case (state)
      RST: state_n = FETCH;
      FETCH: begin
        Mem_Req_o = 1'b1;
        ir_write  = mem_ready_i;
        pc_write  = mem_ready_i;
        state_n   = mem_ready_i ? DECODE : FETCH;
      end
      DECODE:
        case (opcode_i)
          7'b0110011:             state_n = EXEC_R;
          7'b0010011:             state_n = EXEC_I;
          7'b0000011, 7'b0100011: state_n = MEM_ADDR;
          7'b1100011:             state_n = BRANCH;
          7'b1101111:             state_n = JAL;
          7'b0110111:             state_n = LUI_WB;
          default:                state_n = HALT;
        endcase
      EXEC_R: state_n = ALU_WB;
      EXEC_I: begin
        ALU_Src_B_o = 1'b1;
        state_n     = ALU_WB;
      end
      MEM_ADDR: begin
        ALU_Src_B_o = 1'b1;
        state_n     = ALU_Op_o[0] ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        Mem_Req_o = 1'b1;
        IorD_o    = 1'b1;
        state_n   = mem_ready_i ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write    = 1'b1;
        Result_Src_o = 2'b01;
        Instr_Done_o = 1'b1;
        state_n      = FETCH;
      end
      MEM_WRITE: begin
        Mem_Req_o    = 1'b1;
        mem_write    = 1'b1;
        IorD_o       = 1'b1;
        Instr_Done_o = mem_ready_i;
        state_n      = mem_ready_i ? FETCH : MEM_WRITE;
      end
      ALU_WB, LUI_WB: begin
        reg_write    = 1'b1;
        Instr_Done_o = 1'b1;
        state_n      = FETCH;
      end
      BRANCH: begin
        pc_write     = branch_taken_i;
        PC_Src_o     = 1'b1;
        Instr_Done_o = 1'b1;
        state_n      = FETCH;
      end
      JAL: begin
        reg_write    = 1'b1;
        Result_Src_o = 2'b10;
        pc_write     = 1'b1;
        PC_Src_o     = 1'b1;
        Instr_Done_o = 1'b1;
        state_n      = FETCH;
      end
      HALT: Illegal_o = 1'b1;
      default: state_n = RST;
    endcase
  end
  // write enables are suppressed in the reset cycle so no architectural state is disturbed
  assign IR_Write_o  = ir_write & ~reset;
  assign PC_Write_o  = pc_write & ~reset;
  assign Reg_Write_o = reg_write & ~reset;
  assign Mem_Write_o = mem_write & ~reset;
`ifdef MULTI_CYCLE_PERF_CNT_EN
  always_ff @(posedge clk)
    if (reset) begin
      Cycle_Count_o <= '0;
      Instret_o     <= '0;
    end else if (state != HALT) begin
      Cycle_Count_o <= Cycle_Count_o + 32'd1;
      if (Instr_Done_o) Instret_o <= Instret_o + 32'd1;
    end
`else
  assign Cycle_Count_o = '0;
  assign Instret_o     = '0;
`endif
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: scoreboard bench; per-cycle expected output vectors are queued per instruction and checked each cycle.
module tb_multi_cycle_control;
  logic        clk, reset, branch_taken_i, mem_ready_i;
  logic [6:0]  opcode_i;
  logic [2:0]  ALU_Op_o;
  logic        ALU_Src_B_o, IorD_o, Mem_Req_o, Mem_Write_o, IR_Write_o, PC_Write_o, PC_Src_o, Reg_Write_o;
  logic [1:0]  Result_Src_o;
  logic        Instr_Done_o, Illegal_o;
  logic [31:0] Cycle_Count_o, Instret_o;
  multi_cycle_control dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .branch_taken_i(branch_taken_i),
    .mem_ready_i(mem_ready_i), .ALU_Op_o(ALU_Op_o), .ALU_Src_B_o(ALU_Src_B_o), .IorD_o(IorD_o),
    .Mem_Req_o(Mem_Req_o), .Mem_Write_o(Mem_Write_o), .IR_Write_o(IR_Write_o), .PC_Write_o(PC_Write_o),
    .PC_Src_o(PC_Src_o), .Reg_Write_o(Reg_Write_o), .Result_Src_o(Result_Src_o),
    .Instr_Done_o(Instr_Done_o), .Illegal_o(Illegal_o), .Cycle_Count_o(Cycle_Count_o), .Instret_o(Instret_o)
  );
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;
  typedef struct packed {
    logic        ready;
    logic        tk;
    logic [6:0]  op;
    logic [14:0] exp;
    logic [14:0] mask;
  } entry_t;
  entry_t q[$];
  int n_tests = 0, n_fail = 0, ncyc = 0, nret = 0;
  logic [2:0] cls = 3'b000;
  logic [6:0] cur_op;
  logic cur_tk;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [14:0] outv();
    return {ALU_Op_o, ALU_Src_B_o, IorD_o, Mem_Req_o, Mem_Write_o, IR_Write_o, PC_Write_o,
            PC_Src_o, Reg_Write_o, Result_Src_o, Instr_Done_o, Illegal_o};
  endfunction
  function automatic logic [2:0] cls_of(input logic [6:0] op);
    case (op)
      OP_R:    return 3'b000;
      OP_I:    return 3'b001;
      OP_LUI:  return 3'b010;
      OP_BR:   return 3'b011;
      OP_ST:   return 3'b100;
      OP_LD:   return 3'b101;
      OP_JAL:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction
  task automatic push(input logic rdy, input logic [14:0] exp, input logic [14:0] mask);
    q.push_back('{ready: rdy, tk: cur_tk, op: cur_op, exp: exp, mask: mask});
  endtask
  task automatic drain(input string tag);
    entry_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      opcode_i       = e.op;
      mem_ready_i    = e.exp[9] ? e.ready : 1'($urandom_range(0, 1));
      branch_taken_i = e.op == OP_BR ? e.tk : 1'($urandom_range(0, 1));
      #1;
      check(tag, 32'(outv() & ~e.mask), 32'(e.exp & ~e.mask));
`ifdef MULTI_CYCLE_PERF_CNT_EN
      check({tag, "_cyc"}, Cycle_Count_o, 32'(ncyc + 1));
      check({tag, "_ret"}, Instret_o, 32'(nret));
`else
      check({tag, "_cyc"}, Cycle_Count_o, 32'd0);
      check({tag, "_ret"}, Instret_o, 32'd0);
`endif
      if (!e.exp[0]) ncyc++;
      if (e.exp[1]) nret++;
    end
  endtask
  task automatic run_instr(input string tag, input logic [6:0] op, input int fw, input int mw,
                           input logic tk, input bit cut);
    logic [2:0] c;
    c = cls_of(op);
    cur_op = op;
    cur_tk = tk;
    for (int i = 0; i < fw; i++) push(1'b0, {cls, 12'b0_0_1_0_0_0_0_0_00_0_0}, '0);
    push(1'b1, {cls, 12'b0_0_1_0_1_1_0_0_00_0_0}, '0);
    push(1'b0, {cls, 12'b0}, '0);
    case (op)
      OP_R, OP_I: begin
        push(1'b0, {c, op == OP_I, 11'b0}, '0);
        push(1'b0, {c, 12'b0_0_0_0_0_0_0_1_00_1_0}, '0);
      end
      OP_LD: begin
        push(1'b0, {c, 12'b1_0_0_0_0_0_0_0_00_0_0}, '0);
        for (int i = 0; i < mw; i++) push(1'b0, {c, 12'b0_1_1_0_0_0_0_0_00_0_0}, '0);
        push(1'b1, {c, 12'b0_1_1_0_0_0_0_0_00_0_0}, '0);
        push(1'b0, {c, 12'b0_0_0_0_0_0_0_1_01_1_0}, '0);
      end
      OP_ST: begin
        push(1'b0, {c, 12'b1_0_0_0_0_0_0_0_00_0_0}, '0);
        for (int i = 0; i < mw; i++) push(1'b0, {c, 12'b0_1_1_1_0_0_0_0_00_0_0}, '0);
        if (!cut) push(1'b1, {c, 12'b0_1_1_1_0_0_0_0_00_1_0}, '0);
      end
      OP_BR:  push(1'b0, {c, 5'b0, tk, 6'b1_0_00_1_0}, '0);
      OP_JAL: push(1'b0, {c, 12'b0_0_0_0_0_1_1_1_10_1_0}, '0);
      OP_LUI: push(1'b0, {c, 12'b0_0_0_0_0_0_0_1_00_1_0}, '0);
      default: for (int i = 0; i < 20; i++) push(1'b0, {3'b000, 12'b0_0_0_0_0_0_0_0_00_0_1}, 15'h7000);
    endcase
    cls = c;
    drain(tag);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_we", 32'({IR_Write_o, PC_Write_o, Reg_Write_o, Mem_Write_o}), 32'd0);
    @(negedge clk);
    #1;
    check("rst_state", 32'(outv()), 32'd0);
    check("rst_cyc", Cycle_Count_o, 32'd0);
    check("rst_ret", Instret_o, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_rel", 32'(outv()), 32'd0);
    cls  = 3'b000;
    ncyc = 0;
    nret = 0;
  endtask
  initial begin
    reset = 1'b1;
    opcode_i = 7'b0;
    branch_taken_i = 1'b0;
    mem_ready_i = 1'b1;
    do_reset();
    run_instr("r_type", OP_R, 0, 0, 1'b0, 1'b0);
    run_instr("i_type_fwait", OP_I, 2, 0, 1'b0, 1'b0);
    run_instr("load_wait3", OP_LD, 0, 3, 1'b0, 1'b0);
    run_instr("store_wait2", OP_ST, 0, 2, 1'b0, 1'b0);
    run_instr("br_taken", OP_BR, 0, 0, 1'b1, 1'b0);
    run_instr("br_not_taken", OP_BR, 1, 0, 1'b0, 1'b0);
    run_instr("jal", OP_JAL, 0, 0, 1'b0, 1'b0);
    run_instr("lui", OP_LUI, 0, 0, 1'b0, 1'b0);
    run_instr("load_fast", OP_LD, 0, 0, 1'b0, 1'b0);
    run_instr("store_fast", OP_ST, 1, 0, 1'b0, 1'b0);
    run_instr("r_after", OP_R, 0, 0, 1'b0, 1'b0);
    run_instr("store_cut", OP_ST, 0, 2, 1'b0, 1'b1);
    do_reset();
    run_instr("illegal", OP_BAD, 0, 0, 1'b0, 1'b0);
    do_reset();
    run_instr("r_post_halt", OP_R, 0, 0, 1'b0, 1'b0);
    run_instr("jal_post_halt", OP_JAL, 3, 0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
